// File: rtl/elm_weight_addr_gen_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// elm_addr_pkg: state encoding and tag-bit layout shared by the weight
// address generator and its multiplier-aligned tag delay line.   Rev 1.0
// ----------------------------------------------------------------------------
package elm_addr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int TAG_V     = 0;
  localparam int TAG_FIRST = 1;
  localparam int TAG_LROW  = 2;
  localparam int TAG_LALL  = 3;
  localparam int TAG_W     = 4;

endpackage
`default_nettype wire

// File: rtl/elm_weight_addr_gen_tag_delay.sv
`default_nettype none
// ----------------------------------------------------------------------------
// elm_tag_delay: DEPTH-stage shift register with synchronous flush, used to
// line issue-time tags up with the multiplier output.            Rev 1.0
// ----------------------------------------------------------------------------
module elm_tag_delay #(
  parameter int W     = 4,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH*W-1:0] r_pipe;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst_n || flush) r_pipe <= '0;
        else                 r_pipe <= din;
      end
    end else begin : g_deep
      // Newest tag enters at the bottom slice; the top slice is the output.
      always_ff @(posedge clk) begin
        if (!rst_n || flush) r_pipe <= '0;
        else                 r_pipe <= {r_pipe[(DEPTH-1)*W-1:0], din};
      end
    end
  endgenerate

  assign dout = r_pipe[DEPTH*W-1 -: W];

endmodule
`default_nettype wire

// File: rtl/elm_weight_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// elm_weight_addr_gen: row-major weight-ROM address sweep with accumulator
// clear/dump and done strobes aligned to the multiplier output.  Rev 1.0
// ----------------------------------------------------------------------------
import elm_addr_pkg::*;

module elm_weight_addr_gen #(
  parameter int AW            = 10,
  parameter int CW            = 10,
  parameter int RW            = 8,
  parameter int MUL_LAT       = 3,
  parameter int HOLD_ON_STALL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] n_cols,
  input  logic [RW-1:0] n_rows,
  input  logic          adv,
  input  logic          clr,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          busy,
  output logic          acc_clr,
  output logic          acc_dump,
  output logic          done
);

  state_t        r_state;
  logic [CW-1:0] r_ncols;
  logic [RW-1:0] r_nrows;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_addr;
  logic          r_zero_done;

  logic             w_issue;
  logic             w_last_col;
  logic             w_last_all;
  logic [AW-1:0]    w_next_base;
  logic [TAG_W-1:0] w_tag_in;
  logic [TAG_W-1:0] w_tag_out;
  logic             w_tag_done;

  assign w_issue     = (r_state == RUN) && adv;
  assign w_last_col  = (r_col == r_ncols - CW'(1));
  assign w_last_all  = w_last_col && (r_row == r_nrows - RW'(1));
  // Row base advances by addition so the address needs no multiplier.
  assign w_next_base = r_base + AW'(r_ncols);

  always_comb begin
    w_tag_in            = '0;
    w_tag_in[TAG_V]     = w_issue;
    w_tag_in[TAG_FIRST] = (r_col == '0);
    w_tag_in[TAG_LROW]  = w_last_col;
    w_tag_in[TAG_LALL]  = w_last_all;
  end

  elm_tag_delay #(
    .W     (TAG_W),
    .DEPTH (MUL_LAT)
  ) u_tag_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .din   (w_tag_in),
    .dout  (w_tag_out)
  );

  assign w_tag_done = w_tag_out[TAG_V] & w_tag_out[TAG_LALL];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ncols     <= '0;
      r_nrows     <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_base      <= '0;
      r_addr      <= '0;
      r_zero_done <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_base      <= '0;
      r_addr      <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (n_cols != '0 && n_rows != '0) begin
              r_ncols <= n_cols;
              r_nrows <= n_rows;
              r_state <= RUN;
            end else begin
              r_zero_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (adv) begin
            if (w_last_all) begin
              r_col   <= '0;
              r_row   <= '0;
              r_base  <= '0;
              r_addr  <= '0;
              r_state <= DRAIN;
            end else if (w_last_col) begin
              r_col  <= '0;
              r_row  <= r_row + RW'(1);
              r_base <= w_next_base;
              r_addr <= w_next_base;
            end else begin
              r_col  <= r_col + CW'(1);
              r_addr <= r_addr + AW'(1);
            end
          end else if (HOLD_ON_STALL == 0) begin
            // Legacy behaviour: a stall throws the sweep back to the origin.
            r_col  <= '0;
            r_row  <= '0;
            r_base <= '0;
            r_addr <= '0;
          end
        end
        DRAIN: begin
          if (w_tag_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign addr     = r_addr;
  assign col      = r_col;
  assign row      = r_row;
  assign busy     = (r_state != IDLE);
  assign acc_clr  = w_tag_out[TAG_V] & w_tag_out[TAG_FIRST];
  assign acc_dump = w_tag_out[TAG_V] & w_tag_out[TAG_LROW];
  assign done     = w_tag_done | r_zero_done;

endmodule
`default_nettype wire

// File: tb/tb_elm_weight_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_elm_weight_addr_gen: scoreboard bench for the weight address generator,
// covering a hold-on-stall instance and a legacy restart instance. Rev 1.0
// ----------------------------------------------------------------------------
module tb_elm_weight_addr_gen;

  localparam int MUL_LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, adv, clr;
  logic [9:0] n_cols;
  logic [7:0] n_rows;
  logic [9:0] addr, col;
  logic [7:0] row;
  logic       busy, acc_clr, acc_dump, done;

  logic       l_start, l_adv, l_clr;
  logic [9:0] l_addr, l_col;
  logic [7:0] l_row;
  logic       l_busy, l_acc_clr, l_acc_dump, l_done;

  always #5 clk = ~clk;

  elm_weight_addr_gen #(
    .AW(10), .CW(10), .RW(8), .MUL_LAT(MUL_LAT), .HOLD_ON_STALL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_cols(n_cols), .n_rows(n_rows),
    .adv(adv), .clr(clr), .addr(addr), .col(col), .row(row), .busy(busy),
    .acc_clr(acc_clr), .acc_dump(acc_dump), .done(done)
  );

  elm_weight_addr_gen #(
    .AW(10), .CW(10), .RW(8), .MUL_LAT(MUL_LAT), .HOLD_ON_STALL(0)
  ) dut_legacy (
    .clk(clk), .rst_n(rst_n), .start(l_start), .n_cols(n_cols), .n_rows(n_rows),
    .adv(l_adv), .clr(l_clr), .addr(l_addr), .col(l_col), .row(l_row), .busy(l_busy),
    .acc_clr(l_acc_clr), .acc_dump(l_acc_dump), .done(l_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [2:0] bits; } tag_exp_t;
  typedef struct { int addr; int row; int col; } addr_exp_t;

  tag_exp_t  tq[$];
  addr_exp_t aq[$];
  int checks = 0, failures = 0;
  int ev_count = 0, last_done_cyc = 0;
  bit busy_low_pending = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tag events are popped in issue order; addresses are popped on each issue cycle.
  task automatic monitor();
    addr_exp_t a;
    tag_exp_t  t;
    forever begin
      @(negedge clk);
      if (busy_low_pending) begin
        check("busy_after_done", busy, 0);
        busy_low_pending = 0;
      end
      if (adv && busy) begin
        if (aq.size() == 0) check("unexpected_issue", addr, -1);
        else begin
          a = aq.pop_front();
          check("addr", addr, a.addr);
          check("row", row, a.row);
          check("col", col, a.col);
        end
      end
      if (acc_clr || acc_dump || done) ev_count++;
      if (done) begin
        last_done_cyc    = cyc;
        busy_low_pending = 1;
      end
      if (tq.size() != 0 && tq[0].cyc == cyc) begin
        t = tq.pop_front();
        check("tag_clr_dump_done", {acc_clr, acc_dump, done}, t.bits);
      end else if (acc_clr || acc_dump || done) begin
        check("spurious_tag", {acc_clr, acc_dump, done}, 0);
      end else if (tq.size() != 0 && tq[0].cyc < cyc) begin
        t = tq.pop_front();
        check("missed_tag_cycle", cyc, t.cyc);
      end
    end
  endtask

  task automatic issue(input int e, input int nc, input int nr);
    addr_exp_t a;
    tag_exp_t  t;
    int r, c;
    bit last;
    r    = e / nc;
    c    = e % nc;
    last = (e == nc * nr - 1);
    adv  = 1'b1;
    a.addr = e % 1024; a.row = r; a.col = c;
    aq.push_back(a);
    if (c == 0 || c == nc - 1 || last) begin
      t.cyc  = cyc + MUL_LAT;
      t.bits = {c == 0, c == nc - 1, last};
      tq.push_back(t);
    end
    tick();
    adv = 1'b0;
  endtask

  task automatic prune(input int k);
    while (tq.size() != 0 && tq[$].cyc > k) void'(tq.pop_back());
  endtask

  task automatic do_start(input int nc, input int nr);
    n_cols = 10'(nc);
    n_rows = 8'(nr);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || tq.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check(name, int'(n < 50), 1);
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_addr"}, addr, 0);
    check({name, "_col"}, col, 0);
    check({name, "_row"}, row, 0);
    check({name, "_strobes"}, {acc_clr, acc_dump, done}, 0);
  endtask

  initial begin
    int s2, d2, s3, rc, n, ev0;
    bit seen;
    tag_exp_t t;
    rst_n = 1'b0; start = 1'b0; adv = 1'b0; clr = 1'b0;
    n_cols = '0; n_rows = '0;
    l_start = 1'b0; l_adv = 1'b0; l_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_idle("reset");
    fork monitor(); join_none

    // Reset held three cycles in the middle of a sweep
    do_start(4, 3);
    for (int e = 0; e < 5; e++) issue(e, 4, 3);
    rst_n = 1'b0;
    prune(cyc);
    repeat (3) tick();
    rst_n = 1'b1;
    check_idle("midsweep_reset");
    tick();

    // Uninterrupted 4x3 sweep
    s2 = cyc;
    do_start(4, 3);
    check("busy_after_start", busy, 1);
    for (int e = 0; e < 12; e++) issue(e, 4, 3);
    wait_idle("sweep_drain");
    d2 = last_done_cyc - s2;

    // Same sweep with a five-cycle stall at addr 6
    s3 = cyc;
    do_start(4, 3);
    for (int e = 0; e < 6; e++) issue(e, 4, 3);
    repeat (5) begin
      check("stall_addr_hold", addr, 6);
      tick();
    end
    for (int e = 6; e < 12; e++) issue(e, 4, 3);
    wait_idle("stall_drain");
    check("stall_done_delay", (last_done_cyc - s3) - d2, 5);

    // Legacy instance: a stall restarts the sweep from the origin
    n_cols = 10'd4; n_rows = 8'd3; l_start = 1'b1;
    tick();
    l_start = 1'b0;
    for (int e = 0; e < 6; e++) begin
      l_adv = 1'b1;
      check("leg_addr", l_addr, e);
      tick();
    end
    l_adv = 1'b0;
    check("leg_stall_addr", l_addr, 6);
    tick();
    check("leg_restart_addr", l_addr, 0);
    check("leg_restart_row", l_row, 0);
    check("leg_restart_col", l_col, 0);
    check("leg_restart_busy", l_busy, 1);
    rc = cyc;
    for (int i = 0; i < 12; i++) begin
      l_adv = 1'b1;
      check("leg_readdr", l_addr, i);
      if (i == 3) begin
        check("leg_acc_clr_reissue", l_acc_clr, 1);
        check("leg_acc_dump_quiet", l_acc_dump, 0);
      end
      tick();
    end
    l_adv = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      if (l_done) begin
        seen = 1;
        check("leg_done_cycle", cyc, rc + 11 + MUL_LAT);
      end else begin
        tick();
        n++;
      end
    end
    check("leg_done_seen", seen, 1);
    n = 0;
    while (l_busy && n < 10) begin tick(); n++; end
    check("leg_idle", l_busy, 0);

    // Abort with clr at addr 5
    do_start(4, 3);
    for (int e = 0; e < 5; e++) issue(e, 4, 3);
    check("pre_clr_addr", addr, 5);
    clr = 1'b1;
    prune(cyc);
    tick();
    clr = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_addr", addr, 0);
    ev0 = ev_count;
    repeat (10) tick();
    check("clr_no_strobes", ev_count - ev0, 0);

    // 784x2 sweep wraps the 10-bit address; a start mid-sweep is ignored
    do_start(784, 2);
    for (int e = 0; e < 1568; e++) begin
      if (e == 10) begin
        start = 1'b1; n_cols = 10'd5; n_rows = 8'd1;
      end else if (e == 11) begin
        start = 1'b0; n_cols = 10'd784; n_rows = 8'd2;
      end
      if (e == 1567) begin
        check("wrap_final_addr", addr, 543);
        check("wrap_final_row", row, 1);
        check("wrap_final_col", col, 783);
      end
      issue(e, 784, 2);
    end
    wait_idle("wrap_drain");

    // Zero rows: done next cycle, no sweep
    n_cols = 10'd4; n_rows = 8'd0; start = 1'b1;
    t.cyc = cyc + 1; t.bits = 3'b001;
    tq.push_back(t);
    tick();
    start = 1'b0;
    check("zero_rows_done", done, 1);
    check("zero_rows_busy", busy, 0);
    tick();
    check("zero_rows_busy_after", busy, 0);
    repeat (2) tick();

    check("tag_queue_empty", tq.size(), 0);
    check("addr_queue_empty", aq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
